// File: rtl/s_spi_if.sv
// SPI pins and register-bus side of the s_spi responder, grouped for one port.
interface s_spi_if #(
   parameter int AWIDTH = 16,
   parameter int DWIDTH = 8
) ();
   logic              mcs;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic              miso_oe;
   logic              o_wr_evt;
   logic [AWIDTH-1:0] o_wr_addr;
   logic [DWIDTH-1:0] o_wr_data;
   logic              o_rd_req;
   logic [AWIDTH-1:0] o_rd_addr;
   logic              i_rd_vld;
   logic [DWIDTH-1:0] i_rd_data;
   logic              o_rw_done_evt;
   logic              o_rd_err;
   logic              o_abort_evt;

   modport slave (
      input  mcs, sclk, mosi, i_rd_vld, i_rd_data,
      output miso, miso_oe, o_wr_evt, o_wr_addr, o_wr_data, o_rd_req, o_rd_addr,
             o_rw_done_evt, o_rd_err, o_abort_evt
   );

   modport master (
      output mcs, sclk, mosi, i_rd_vld, i_rd_data,
      input  miso, miso_oe, o_wr_evt, o_wr_addr, o_wr_data, o_rd_req, o_rd_addr,
             o_rw_done_evt, o_rd_err, o_abort_evt
   );
endinterface

// File: rtl/s_spi.sv
// SPI responder: oversamples mcs/sclk/mosi in user_clk and turns rw+addr+data frames
// into register-bus write events and read requests, returning read data on miso.
module s_spi #(
   parameter logic       MCS_VALID_LEVEL = 1'b0,
   parameter logic [1:0] SCK_MODE        = 2'b01,
   parameter int         AWIDTH          = 16,
   parameter int         DWIDTH          = 8,
   parameter int         SYNC_STAGES     = 2
) (
   input  logic   user_clk,
   input  logic   user_rst,
   s_spi_if.slave bus
);
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CMD     = 3'd1;
   localparam logic [2:0] ST_WDATA   = 3'd2;
   localparam logic [2:0] ST_RD_WAIT = 3'd3;
   localparam logic [2:0] ST_RDATA   = 3'd4;
   localparam logic [2:0] ST_TAIL    = 3'd5;
   localparam int         CNT_W      = $clog2((AWIDTH > DWIDTH ? AWIDTH : DWIDTH) + 1);

   logic [SYNC_STAGES-1:0] cs_sync_p0;
   logic [SYNC_STAGES-1:0] sck_sync_p0;
   logic [SYNC_STAGES-1:0] sdi_sync_p0;
   logic                   cs_act_p1;
   logic                   sck_p1;

   logic                   cs_act;
   logic                   cs_start;
   logic                   sck_now;
   logic                   sdi;
   logic                   cap;
   logic                   launch;

   logic [2:0]             state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [AWIDTH-1:0]      cmd_sr;
   logic [AWIDTH-1:0]      cmd_addr;
   logic [AWIDTH-1:0]      addr_q;
   logic [DWIDTH-1:0]      dat_sr;
   logic [DWIDTH-1:0]      rd_word;
   logic                   rd_loaded;

   logic                   miso_q;
   logic                   miso_oe_q;
   logic                   wr_evt_q;
   logic [AWIDTH-1:0]      wr_addr_q;
   logic [DWIDTH-1:0]      wr_data_q;
   logic                   rd_req_q;
   logic [AWIDTH-1:0]      rd_addr_q;
   logic                   done_q;
   logic                   rd_err_q;
   logic                   abort_q;

   // Stage p0: pin synchronizers; stage p1: edge-detect history.
   // mcs is tracked as "active" and resets active, so a select held across reset
   // must first be seen inactive before a new frame can start.
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         cs_sync_p0  <= '1;
         sck_sync_p0 <= {SYNC_STAGES{SCK_MODE[1]}};
         sdi_sync_p0 <= '0;
         cs_act_p1   <= 1'b1;
         sck_p1      <= SCK_MODE[1];
      end else begin
         cs_sync_p0  <= {cs_sync_p0[SYNC_STAGES-2:0], bus.mcs == MCS_VALID_LEVEL};
         sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], bus.sclk};
         sdi_sync_p0 <= {sdi_sync_p0[SYNC_STAGES-2:0], bus.mosi};
         cs_act_p1   <= cs_sync_p0[SYNC_STAGES-1];
         sck_p1      <= sck_sync_p0[SYNC_STAGES-1];
      end
   end

   assign cs_act   = cs_sync_p0[SYNC_STAGES-1];
   assign cs_start = cs_act & ~cs_act_p1;
   assign sck_now  = sck_sync_p0[SYNC_STAGES-1];
   assign sdi      = sdi_sync_p0[SYNC_STAGES-1];
   assign cap      = SCK_MODE[0] ? (sck_now & ~sck_p1) : (~sck_now & sck_p1);
   assign launch   = SCK_MODE[0] ? (~sck_now & sck_p1) : (sck_now & ~sck_p1);
   assign cmd_addr = {cmd_sr[AWIDTH-2:0], sdi};

   // Read data that would go out at the first launch edge: zeros if nothing arrived.
   always_comb begin
      rd_word = dat_sr;
      if (!rd_loaded) rd_word = bus.i_rd_vld ? bus.i_rd_data : '0;
   end

   // Stage p2: frame sequencer and register-bus outputs.
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         cmd_sr    <= '0;
         addr_q    <= '0;
         dat_sr    <= '0;
         rd_loaded <= 1'b0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
         wr_evt_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
         done_q    <= 1'b0;
         rd_err_q  <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         wr_evt_q <= 1'b0;
         rd_req_q <= 1'b0;
         done_q   <= 1'b0;
         rd_err_q <= 1'b0;
         abort_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cs_start) begin
                  state     <= ST_CMD;
                  bit_cnt   <= '0;
                  rd_loaded <= 1'b0;
                  miso_oe_q <= 1'b1;
               end
            end
            ST_TAIL: begin
               if (!cs_act) begin
                  state     <= ST_IDLE;
                  miso_oe_q <= 1'b0;
                  miso_q    <= 1'b0;
               end
            end
            default: begin
               if (!cs_act) begin
                  abort_q   <= 1'b1;
                  state     <= ST_IDLE;
                  miso_oe_q <= 1'b0;
                  miso_q    <= 1'b0;
               end else begin
                  case (state)
                     ST_CMD: begin
                        if (cap) begin
                           cmd_sr <= cmd_addr;
                           if (bit_cnt == CNT_W'(AWIDTH)) begin
                              bit_cnt <= '0;
                              addr_q  <= cmd_addr;
                              if (cmd_sr[AWIDTH-1]) begin
                                 rd_addr_q <= cmd_addr;
                                 rd_req_q  <= 1'b1;
                                 state     <= ST_RD_WAIT;
                              end else begin
                                 state <= ST_WDATA;
                              end
                           end else begin
                              bit_cnt <= bit_cnt + 1'b1;
                           end
                        end
                     end
                     ST_WDATA: begin
                        if (cap) begin
                           dat_sr <= {dat_sr[DWIDTH-2:0], sdi};
                           if (bit_cnt == CNT_W'(DWIDTH - 1)) begin
                              wr_evt_q  <= 1'b1;
                              done_q    <= 1'b1;
                              wr_addr_q <= addr_q;
                              wr_data_q <= {dat_sr[DWIDTH-2:0], sdi};
                              state     <= ST_TAIL;
                           end else begin
                              bit_cnt <= bit_cnt + 1'b1;
                           end
                        end
                     end
                     ST_RD_WAIT: begin
                        if (launch) begin
                           miso_q   <= rd_word[DWIDTH-1];
                           dat_sr   <= {rd_word[DWIDTH-2:0], 1'b0};
                           rd_err_q <= ~rd_loaded & ~bus.i_rd_vld;
                           state    <= ST_RDATA;
                        end else if (!rd_loaded && bus.i_rd_vld) begin
                           dat_sr    <= bus.i_rd_data;
                           rd_loaded <= 1'b1;
                           miso_q    <= bus.i_rd_data[DWIDTH-1];
                        end
                     end
                     ST_RDATA: begin
                        if (launch) begin
                           miso_q <= dat_sr[DWIDTH-1];
                           dat_sr <= {dat_sr[DWIDTH-2:0], 1'b0};
                        end
                        if (cap) begin
                           if (bit_cnt == CNT_W'(DWIDTH - 1)) begin
                              done_q <= 1'b1;
                              miso_q <= 1'b0;
                              state  <= ST_TAIL;
                           end else begin
                              bit_cnt <= bit_cnt + 1'b1;
                           end
                        end
                     end
                     default: begin
                        state     <= ST_IDLE;
                        miso_oe_q <= 1'b0;
                        miso_q    <= 1'b0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.miso          = miso_q;
   assign bus.miso_oe       = miso_oe_q;
   assign bus.o_wr_evt      = wr_evt_q;
   assign bus.o_wr_addr     = wr_addr_q;
   assign bus.o_wr_data     = wr_data_q;
   assign bus.o_rd_req      = rd_req_q;
   assign bus.o_rd_addr     = rd_addr_q;
   assign bus.o_rw_done_evt = done_q;
   assign bus.o_rd_err      = rd_err_q;
   assign bus.o_abort_evt   = abort_q;
endmodule
